// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchroniser, per-channel debounce FSM and
// one-cycle press / release / long-press strobes, all in the clk domain.
module button_conditioner #(
  parameter int N_BTN           = 2,
`ifdef DEBUG
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 20
`else
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int LONG_CYCLES     = 27000000
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BTN-1:0]     btn_n,
  output logic [N_BTN-1:0]     pressed,
  output logic [N_BTN-1:0]     press_pulse,
  output logic [N_BTN-1:0]     release_pulse,
  output logic [N_BTN-1:0]     long_pulse,
  output logic [2*N_BTN-1:0]   state_dbg
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW  = $clog2(LONG_CYCLES + 1);

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } state_t;

  // Reset to released so a button held through reset is seen as a fresh press.
  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  assign s = ~sync2;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_t          state_q, state_d;
    logic [DBW-1:0]  db_q, db_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            pressed_q, pressed_d;
    logic            press_q, press_d;
    logic            rel_q, rel_d;
    logic            long_q, long_d;

    always_comb begin
      state_d   = state_q;
      db_d      = db_q;
      hold_d    = hold_q;
      pressed_d = pressed_q;
      press_d   = 1'b0;
      rel_d     = 1'b0;
      long_d    = 1'b0;

      // Hold time keeps running through a release bounce; only a new press clears it.
      if (state_q == HELD || state_q == REL_WAIT) begin
        if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HW'(1);
        end
        if (hold_q == HOLD_LAST) begin
          long_d = 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (s[i]) begin
            state_d = PRESS_WAIT;
            db_d    = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s[i]) begin
            state_d = IDLE;
            db_d    = '0;
          end else if (db_q == DB_LAST) begin
            state_d   = HELD;
            db_d      = '0;
            hold_d    = '0;
            pressed_d = 1'b1;
            press_d   = 1'b1;
          end else begin
            db_d = db_q + DBW'(1);
          end
        end
        HELD: begin
          if (!s[i]) begin
            state_d = REL_WAIT;
            db_d    = '0;
          end
        end
        REL_WAIT: begin
          if (s[i]) begin
            state_d = HELD;
            db_d    = '0;
          end else if (db_q == DB_LAST) begin
            state_d   = IDLE;
            db_d      = '0;
            pressed_d = 1'b0;
            rel_d     = 1'b1;
          end else begin
            db_d = db_q + DBW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          db_d    = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= IDLE;
        db_q      <= '0;
        hold_q    <= '0;
        pressed_q <= 1'b0;
        press_q   <= 1'b0;
        rel_q     <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        db_q      <= db_d;
        hold_q    <= hold_d;
        pressed_q <= pressed_d;
        press_q   <= press_d;
        rel_q     <= rel_d;
        long_q    <= long_d;
      end
    end

    assign pressed[i]             = pressed_q;
    assign press_pulse[i]         = press_q;
    assign release_pulse[i]       = rel_q;
    assign long_pulse[i]          = long_q;
    assign state_dbg[2*i +: 2]    = state_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bouncing buttons,
// checked cycle by cycle against a run-length reference model through a scoreboard.
module tb_button_conditioner;

  localparam int N  = 2;
  localparam int DB = 4;
  localparam int LG = 20;
  localparam int W  = 4 * N;

  logic           clk;
  logic           rst;
  logic [N-1:0]   btn_n;
  logic [N-1:0]   pressed;
  logic [N-1:0]   press_pulse;
  logic [N-1:0]   release_pulse;
  logic [N-1:0]   long_pulse;
  logic [2*N-1:0] state_dbg;

  button_conditioner #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LG)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_n        (btn_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard: {pressed, press_pulse, release_pulse, long_pulse}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_act;
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: s is the button level seen two edges ago; a level is accepted
  // once DB+1 consecutive samples disagree with the currently accepted level.
  logic [N-1:0] m_d1;
  logic [N-1:0] m_d2;
  logic [N-1:0] m_lvl;
  int           m_run[N];
  int           m_held[N];

  task automatic step(input logic r, input logic [N-1:0] b);
    logic [N-1:0] s;
    logic [N-1:0] pp;
    logic [N-1:0] rp;
    logic [N-1:0] lp;
    rst   = r;
    btn_n = b;
    @(posedge clk);
    pp = '0;
    rp = '0;
    lp = '0;
    if (r) begin
      m_d1  = '0;
      m_d2  = '0;
      m_lvl = '0;
      for (int i = 0; i < N; i++) begin
        m_run[i]  = 0;
        m_held[i] = 0;
      end
    end else begin
      s    = m_d2;
      m_d2 = m_d1;
      m_d1 = ~b;
      for (int i = 0; i < N; i++) begin
        if (m_lvl[i]) begin
          if (m_held[i] == LG - 1) lp[i] = 1'b1;
          if (m_held[i] < LG) m_held[i] = m_held[i] + 1;
        end
        if (s[i] != m_lvl[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DB + 1) begin
            m_run[i] = 0;
            m_lvl[i] = s[i];
            if (s[i]) begin
              pp[i]     = 1'b1;
              m_held[i] = 0;
            end else begin
              rp[i] = 1'b1;
            end
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    exp_q.push_back({m_lvl, pp, rp, lp});
    @(negedge clk);
  endtask

  task automatic hold(input logic r, input logic [N-1:0] b, input int n);
    for (int k = 0; k < n; k++) step(r, b);
  endtask

  // monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {pressed, press_pulse, release_pulse, long_pulse};
      n_tests++;
      if (mon_act !== mon_exp) begin
        n_fail++;
        $display("FAIL outputs t=%0t pressed/press/release/long got %b/%b/%b/%b expected %b/%b/%b/%b",
                 $time, mon_act[4*N-1 -: N], mon_act[3*N-1 -: N], mon_act[2*N-1 -: N],
                 mon_act[N-1:0], mon_exp[4*N-1 -: N], mon_exp[3*N-1 -: N],
                 mon_exp[2*N-1 -: N], mon_exp[N-1:0]);
      end
    end
  end

  // driver
  logic [N-1:0] cur;
  int           left[N];

  initial begin
    // 1: reset with both held, then press accepted on both channels together
    hold(1'b1, 2'b00, 3);
    hold(1'b0, 2'b00, 10);
    hold(1'b0, 2'b11, 10);
    // 2: short glitch on btn0 ignored, then a real press
    hold(1'b0, 2'b10, 3);
    hold(1'b0, 2'b11, 8);
    hold(1'b0, 2'b10, 10);
    // 3: keep holding btn0 past the long-press time
    hold(1'b0, 2'b10, 30);
    // 4: release with a 2-cycle bounce
    hold(1'b0, 2'b11, 2);
    hold(1'b0, 2'b10, 2);
    hold(1'b0, 2'b11, 12);
    // 5: short press on btn1 only
    hold(1'b0, 2'b01, 10);
    hold(1'b0, 2'b11, 12);
    // 6: reset while btn0 held with hold time 10, button stays down
    hold(1'b0, 2'b10, 7 + 10);
    hold(1'b1, 2'b10, 1);
    hold(1'b0, 2'b10, 35);
    hold(1'b0, 2'b11, 12);
    // random bouncing on both channels, occasional reset
    cur = '1;
    for (int i = 0; i < N; i++) left[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (left[i] == 0) begin
          cur[i]  = ~cur[i];
          left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DB + 1))
                                                : int'($urandom_range(DB + 2, 40));
        end else begin
          left[i] = left[i] - 1;
        end
      end
      step($urandom_range(0, 249) == 0, cur);
    end
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending got %0d expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
